// File: rtl/fetch_pc_gen.sv
// Fetch-stage next-PC generator: holds the fetch PC, picks the next one by priority,
// and derives the IM word index, fetch address error, delay-slot flag and fetch count.
module fetch_pc_gen #(
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_PC   = 32'h0000_4180,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int          IM_DEPTH = 4096,
    parameter int          CNT_W    = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        stall,
    input  logic                        exc_req,
    input  logic                        eret,
    input  logic [ADDR_W-1:0]           epc,
    input  logic                        jr,
    input  logic [ADDR_W-1:0]           jr_target,
    input  logic                        jump,
    input  logic [ADDR_W-1:0]           jump_target,
    input  logic                        branch,
    input  logic [ADDR_W-1:0]           branch_target,
    input  logic                        d_is_ctrl,
    output logic [ADDR_W-1:0]           pc,
    output logic [ADDR_W-1:0]           pc_plus8,
    output logic [$clog2(IM_DEPTH)-1:0] im_addr,
    output logic                        adel,
    output logic [4:0]                  exc_code,
    output logic                        bd,
    output logic [CNT_W-1:0]            fetch_cnt
);

    localparam int                IM_AW     = $clog2(IM_DEPTH);
    localparam logic [ADDR_W-1:0] RESET_A   = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] EXC_A     = ADDR_W'(EXC_PC);
    localparam logic [ADDR_W-1:0] IM_BASE_A = ADDR_W'(IM_BASE);
    // End of the IM window is formed one bit wider so a window touching the top never wraps.
    localparam logic [ADDR_W:0]   IM_SPAN   = (ADDR_W+1)'(IM_DEPTH) << 2;
    localparam logic [ADDR_W:0]   IM_END    = {1'b0, IM_BASE_A} + IM_SPAN;
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [ADDR_W-1:0] next_pc_s;
    logic              next_bd_s;
    logic              advance_s;
    logic [ADDR_W-1:0] offset_s;

    // Next-PC priority select; exception and ERET override a stall.
    always_comb begin
        next_pc_s = pc;
        next_bd_s = bd;
        advance_s = 1'b1;
        if (exc_req) begin
            next_pc_s = EXC_A;
            next_bd_s = 1'b0;
        end else if (eret) begin
            next_pc_s = epc;
            next_bd_s = 1'b0;
        end else if (stall) begin
            advance_s = 1'b0;
        end else begin
            next_bd_s = d_is_ctrl;
            if (jr) begin
                next_pc_s = jr_target;
            end else if (jump) begin
                next_pc_s = jump_target;
            end else if (branch) begin
                next_pc_s = branch_target;
            end else begin
                next_pc_s = pc + ADDR_W'(32'd4);
            end
        end
    end

    // PC, delay-slot flag and saturating advance counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= RESET_A;
            bd        <= 1'b0;
            fetch_cnt <= '0;
        end else begin
            pc <= next_pc_s;
            bd <= next_bd_s;
            if (advance_s && (fetch_cnt != CNT_MAX)) begin
                fetch_cnt <= fetch_cnt + CNT_W'(32'd1);
            end
        end
    end

    // Address checks on the current PC; a faulting fetch gets word index 0.
    always_comb begin
        offset_s = pc - IM_BASE_A;
        adel     = (pc[1:0] != 2'b00) || (pc < IM_BASE_A) || ({1'b0, pc} >= IM_END);
        if (adel) begin
            im_addr  = '0;
            exc_code = 5'd4;
        end else begin
            im_addr  = IM_AW'(offset_s >> 2);
            exc_code = 5'd0;
        end
        pc_plus8 = pc + ADDR_W'(32'd8);
    end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen: default instance plus a 16-bit-PC / 4-bit-counter instance,
// both driven by the same stimulus and checked against an arithmetic reference model.
module tb_fetch_pc_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0, exc_req = 1'b0, eret = 1'b0;
    logic        jr = 1'b0, jump = 1'b0, branch = 1'b0, d_is_ctrl = 1'b0;
    logic [31:0] epc = 32'h0, jr_target = 32'h0, jump_target = 32'h0, branch_target = 32'h0;

    logic [31:0] pc, pc_plus8, fetch_cnt;
    logic [11:0] im_addr;
    logic        adel, bd;
    logic [4:0]  exc_code;

    logic [15:0] pc2, pc_plus8_2;
    logic [11:0] im_addr2;
    logic        adel2, bd2;
    logic [4:0]  exc_code2;
    logic [3:0]  fetch_cnt2;

    fetch_pc_gen dut (
        .clk(clk), .reset(reset), .stall(stall), .exc_req(exc_req), .eret(eret),
        .epc(epc), .jr(jr), .jr_target(jr_target), .jump(jump), .jump_target(jump_target),
        .branch(branch), .branch_target(branch_target), .d_is_ctrl(d_is_ctrl),
        .pc(pc), .pc_plus8(pc_plus8), .im_addr(im_addr), .adel(adel),
        .exc_code(exc_code), .bd(bd), .fetch_cnt(fetch_cnt)
    );

    fetch_pc_gen #(.ADDR_W(16), .CNT_W(4)) dut2 (
        .clk(clk), .reset(reset), .stall(stall), .exc_req(exc_req), .eret(eret),
        .epc(epc[15:0]), .jr(jr), .jr_target(jr_target[15:0]), .jump(jump),
        .jump_target(jump_target[15:0]), .branch(branch), .branch_target(branch_target[15:0]),
        .d_is_ctrl(d_is_ctrl), .pc(pc2), .pc_plus8(pc_plus8_2), .im_addr(im_addr2),
        .adel(adel2), .exc_code(exc_code2), .bd(bd2), .fetch_cnt(fetch_cnt2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int     cyc;
        longint pc, p8, im, adel, ec, bd, cnt;
        longint pc2, p82, im2, adel2, ec2, cnt2;
    } exp_t;
    exp_t q[$];

    localparam longint M32 = 64'h1_0000_0000;
    localparam longint M16 = 64'h1_0000;

    longint m_pc, m_pc2, m_cnt, m_cnt2;
    longint m_bd;

    function automatic void chk(string name, longint act, longint expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, expv);
    endfunction

    function automatic longint f_adel(longint a);
        return ((a % 4) != 0 || a < 64'h3000 || a >= 64'h3000 + 4 * 4096) ? 64'd1 : 64'd0;
    endfunction

    function automatic longint f_im(longint a);
        return (f_adel(a) != 0) ? 64'd0 : (a - 64'h3000) / 4;
    endfunction

    function automatic void load(logic [31:0] t);
        m_pc  = longint'(t);
        m_pc2 = m_pc % M16;
    endfunction

    // Advance the reference model by one edge, queue the expectation, then take the edge.
    task automatic apply();
        exp_t e;
        bit   adv;
        adv = 1'b1;
        if (reset) begin
            m_pc = 64'h3000; m_pc2 = 64'h3000; m_bd = 0; m_cnt = 0; m_cnt2 = 0; adv = 1'b0;
        end else if (exc_req) begin
            load(32'h0000_4180); m_bd = 0;
        end else if (eret) begin
            load(epc); m_bd = 0;
        end else if (stall) begin
            adv = 1'b0;
        end else begin
            m_bd = longint'(d_is_ctrl);
            if (jr)          load(jr_target);
            else if (jump)   load(jump_target);
            else if (branch) load(branch_target);
            else begin
                m_pc  = (m_pc + 4) % M32;
                m_pc2 = (m_pc2 + 4) % M16;
            end
        end
        if (adv) begin
            if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
            if (m_cnt2 < 15) m_cnt2++;
        end
        e.cyc   = cyc + 1;
        e.pc    = m_pc;   e.p8  = (m_pc + 8) % M32;
        e.adel  = f_adel(m_pc);  e.im  = f_im(m_pc);  e.ec  = e.adel * 4;
        e.pc2   = m_pc2;  e.p82 = (m_pc2 + 8) % M16;
        e.adel2 = f_adel(m_pc2); e.im2 = f_im(m_pc2); e.ec2 = e.adel2 * 4;
        e.bd    = m_bd;   e.cnt = m_cnt;  e.cnt2 = m_cnt2;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; stall = 1'b0; exc_req = 1'b0; eret = 1'b0;
        jr = 1'b0; jump = 1'b0; branch = 1'b0; d_is_ctrl = 1'b0;
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] corner [6];
        corner = '{32'h0000_2FFC, 32'h0000_3002, 32'h0000_6FFC,
                   32'h0000_7000, 32'h0000_FFFC, 32'hFFFF_FFFC};
        case ($urandom_range(0, 7))
            4:       return corner[$urandom_range(0, 5)];
            5:       return 32'($urandom);
            6:       return 32'h0000_4180;
            default: return 32'h0000_3000 + 32'($urandom_range(0, 4095)) * 32'd4;
        endcase
    endfunction

    // Monitor: compare every queued expectation at the falling edge of its cycle.
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            chk("cycle",     longint'(cyc),        longint'(e.cyc));
            chk("pc",        longint'(pc),         e.pc);
            chk("pc_plus8",  longint'(pc_plus8),   e.p8);
            chk("im_addr",   longint'(im_addr),    e.im);
            chk("adel",      longint'(adel),       e.adel);
            chk("exc_code",  longint'(exc_code),   e.ec);
            chk("bd",        longint'(bd),         e.bd);
            chk("fetch_cnt", longint'(fetch_cnt),  e.cnt);
            chk("pc16",      longint'(pc2),        e.pc2);
            chk("pc_plus8_16", longint'(pc_plus8_2), e.p82);
            chk("im_addr16", longint'(im_addr2),   e.im2);
            chk("adel16",    longint'(adel2),      e.adel2);
            chk("exc_code16", longint'(exc_code2), e.ec2);
            chk("bd16",      longint'(bd2),        e.bd);
            chk("fetch_cnt4", longint'(fetch_cnt2), e.cnt2);
        end
    end

    initial begin
        @(posedge clk);
        #1;
        // reset then free-running fetch
        apply();
        idle();
        repeat (3) apply();
        // branch held off by a two-cycle stall
        stall = 1'b1; branch = 1'b1; branch_target = 32'h0000_3040; d_is_ctrl = 1'b1;
        repeat (2) apply();
        stall = 1'b0;
        apply();
        // jr beats jump beats branch
        idle();
        jr = 1'b1; jump = 1'b1; branch = 1'b1;
        jr_target = 32'h0000_3100; jump_target = 32'h0000_3200; branch_target = 32'h0000_3300;
        apply();
        // exception beats eret and stall, then eret alone
        idle();
        exc_req = 1'b1; eret = 1'b1; stall = 1'b1; epc = 32'h0000_3010;
        apply();
        idle();
        eret = 1'b1;
        apply();
        // IM window boundaries and misalignment
        idle(); jr = 1'b1; jr_target = 32'h0000_3002; apply();
        jr_target = 32'h0000_2FFC; apply();
        jr_target = 32'h0000_6FFC; apply();
        jr_target = 32'h0000_7000; apply();
        // 16-bit instance wraps from 0xFFFC
        jr_target = 32'h0000_FFFC; apply();
        idle();
        repeat (20) apply();
        // randomized traffic with occasional mid-stream reset
        for (int i = 0; i < 3000; i++) begin
            idle();
            reset         = ($urandom_range(0, 99) < 2);
            stall         = ($urandom_range(0, 99) < 30);
            exc_req       = ($urandom_range(0, 99) < 4);
            eret          = ($urandom_range(0, 99) < 5);
            jr            = ($urandom_range(0, 99) < 10);
            jump          = ($urandom_range(0, 99) < 10);
            branch        = ($urandom_range(0, 99) < 15);
            d_is_ctrl     = 1'($urandom_range(0, 1));
            epc           = rnd_addr();
            jr_target     = rnd_addr();
            jump_target   = rnd_addr();
            branch_target = rnd_addr();
            apply();
        end
        idle();
        repeat (2) apply();
        repeat (2) @(posedge clk);
        chk("drain", longint'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_pc_gen.md
# fetch_pc_gen

Parametrised next-PC generator and fetch-address front end for the pipelined MIPS core. Every cycle it holds the fetch PC and selects the next one from:
- exception entry
- ERET return
- register jump
- immediate jump
- taken branch
- sequential PC+4

Beyond plain PC update, it flags fetch address errors (AdEL), tracks delay-slot status of the fetched instruction, produces the instruction-memory word index, and keeps a saturating fetch counter. It sits in the F stage and feeds the IM and the F/D pipeline register.

## Interface
Parameters:
- ADDR_W, 32, PC width in bits (≥ 16)
- RESET_PC, 32'h0000_3000, PC value loaded on reset
- EXC_PC, 32'h0000_4180, exception handler entry address
- IM_BASE, 32'h0000_3000, byte address of IM word 0
- IM_DEPTH, 4096, IM size in words (power of two)
- CNT_W, 32, fetch counter width

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  hold PC (hazard unit)
- exc_req  in  1  exception taken in M stage
- eret  in  1  ERET retiring
- epc  in  ADDR_W  ERET return address
- jr  in  1  register jump resolved in D
- jr_target  in  ADDR_W  register jump target
- jump  in  1  j/jal resolved in D
- jump_target  in  ADDR_W  immediate jump target
- branch  in  1  branch taken in D
- branch_target  in  ADDR_W  branch target
- d_is_ctrl  in  1  instruction now in D is a branch/jump (taken or not)
- pc  out  ADDR_W  current fetch PC
- pc_plus8  out  ADDR_W  pc + 8 (link value)
- im_addr  out  log2(IM_DEPTH)  IM word index
- adel  out  1  fetch address error on pc
- exc_code  out  5  5'd4 when adel, else 5'd0
- bd  out  1  fetched instruction is a delay slot
- fetch_cnt  out  CNT_W  number of PC advances since reset

## Operation
Next-PC selection, in strict priority:
1. exc_req → EXC_PC
2. eret → epc
3. stall → hold pc
4. jr → jr_target
5. jump → jump_target
6. branch → branch_target
7. otherwise pc + 4

Rules:
- exc_req and eret override stall. exc_req beats a simultaneous eret.
- Arithmetic is modulo 2^ADDR_W. pc + 4 and pc + 8 wrap silently.
- adel (combinational from pc) is 1 when any of these hold:
  - pc[1:0] ≠ 0
  - pc < IM_BASE
  - pc ≥ IM_BASE + 4·IM_DEPTH (computed without overflow at ADDR_W+1 bits)
- im_addr = (pc − IM_BASE)[log2(IM_DEPTH)+1:2] when adel = 0. It is forced to 0 when adel = 1; downstream treats that instruction as a faulting fetch.
- bd register:
  - On exc_req or eret, loads 0.
  - On stall, holds.
  - Otherwise, loads d_is_ctrl.
- fetch_cnt:
  - Increments on every edge where pc loads a new value, i.e. not reset and not stall-hold. Exception and ERET loads count.
  - Saturates at 2^CNT_W − 1.
- Misaligned targets from jr, ERET or exceptions are loaded as given. They are not corrected; adel reports them.

## Timing
- Reset state: pc = RESET_PC, bd = 0, fetch_cnt = 0. adel and im_addr follow from RESET_PC (0 and 0 with defaults). pc_plus8 = RESET_PC + 8.
- Reset has priority over every other input.
- Latency is one cycle: a request sampled at edge N appears on pc after edge N. adel, im_addr, exc_code and pc_plus8 are valid in that same cycle.
- Stall for k cycles: pc, bd and fetch_cnt all frozen for k edges.
- Reset asserted mid-stream: the next edge restores the reset state regardless of pending requests.

## Test plan
- Reset, then 3 free cycles → pc 0x3000, 0x3004, 0x3008, 0x300C; fetch_cnt = 3; adel = 0; im_addr = 3 at 0x300C.
- branch = 1, branch_target = 0x3040 and d_is_ctrl = 1 together with stall = 1 for 2 cycles, then stall = 0 → pc held for 2 cycles, then 0x3040; bd = 1 after the load; fetch_cnt unchanged during the stall.
- jr, jump and branch all = 1 (targets 0x3100, 0x3200, 0x3300) → pc = 0x3100.
- exc_req, eret and stall all = 1, epc = 0x3010 → pc = 0x4180, bd = 0. Next cycle eret only → pc = 0x3010.
- jr_target = 0x3002 → adel = 1, exc_code = 4, im_addr = 0.
- jr_target = 0x2FFC → adel = 1.
- jr_target = 0x6FFC (with IM_DEPTH = 4096) → adel = 0, im_addr = 4095.
- jr_target = 0x7000 → adel = 1.
- CNT_W = 4, 20 free cycles → fetch_cnt saturates at 15.
- ADDR_W = 16, pc = 0xFFFC free-running → pc wraps to 0x0000, adel = 1.
